// File: rtl/mem_arb_pkg.sv
// Shared state encoding and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StAck} arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the two bus masters, one-hot result.
// MEM_ARB_ROUND_ROBIN_EN selects round robin on ties; otherwise m0 has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the master that did not win last time goes first.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == M_CPU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[M_CPU]) begin
      gnt_o[M_CPU] = 1'b1;
    end else if (req_i[M_AUX]) begin
      gnt_o[M_AUX] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data_memory bus between the CPU (m0) and an auxiliary master (m1).
// Tie policy: MEM_ARB_ROUND_ROBIN_EN defined = round robin, undefined = m0 fixed priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MEM_LATENCY = 1   // legal range 1..7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  mem_read,
  output logic                  mem_write
);

  localparam logic [LAT_W-1:0] CntLoad = LAT_W'(MEM_LATENCY - 1);

  arb_state_e            state_q;
  logic [LAT_W-1:0]      cnt_q;
  logic [1:0]            grant_q;
  logic [1:0]            ack_q;
  logic                  last_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;

  logic [1:0]            pick_gnt;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // last_q only feeds the picker; fixed-priority builds leave it without a load.
  arb_pick u_pick (
    .req_i  ({m1_req, m0_req}),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    sel_write = m0_write;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (pick_gnt[M_AUX]) begin
      sel_write = m1_write;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      last_q      <= M_AUX;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      bus_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_gnt != 2'b00) begin
            state_q     <= StAccess;
            cnt_q       <= CntLoad;
            grant_q     <= pick_gnt;
            last_q      <= pick_gnt[M_AUX];
            wr_q        <= sel_write;
            wdata_q     <= sel_wdata;
            bus_addr_q  <= sel_addr;
            mem_read_q  <= ~sel_write;
            mem_write_q <= sel_write;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            state_q     <= StAck;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack_q       <= grant_q;
            if (!wr_q) begin
              if (grant_q[M_CPU]) m0_rdata_q <= bus_data;
              if (grant_q[M_AUX]) m1_rdata_q <= bus_data;
            end
          end else begin
            cnt_q <= cnt_q - LAT_W'(1);
          end
        end
        StAck: begin
          state_q <= StIdle;
          ack_q   <= '0;
          grant_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Drive only while a write owns the bus; reset releases it immediately.
  assign bus_data = (state_q == StAccess && wr_q) ? wdata_q : 'z;

  assign grant     = grant_q;
  assign bus_addr  = bus_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign m0_ack    = ack_q[M_CPU];
  assign m1_ack    = ack_q[M_AUX];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
